// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types and constants for the RC4 key-scheduling stage.
// State encoding, default key geometry and S memory depth live here so the
// top, the key-select sub-module and the bench agree on them.
package ksa_pkg;

    localparam int KEY_LEN = 3;
    localparam int KEY_W   = 24;
    localparam int S_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        WT_I,
        RD_J,
        WT_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

endpackage

// File: rtl/ksa_shuffle_if.sv
// ksa_shuffle_if: controller handshake plus S memory port of the shuffle stage.
// start/complete are levels: start is held high for the whole phase and
// complete stays high in DONE until start is seen low. The memory side has no
// backpressure: address/data/wren are presented every cycle and q returns the
// word at the previous cycle's address (1-cycle read latency).
interface ksa_shuffle_if;

    logic       start;
    logic       complete;
    logic [7:0] address;
    logic [7:0] data;
    logic       wren;
    logic [7:0] q;

    // Shuffle stage side: drives the memory port and complete.
    modport master (
        input  start,
        input  q,
        output complete,
        output address,
        output data,
        output wren
    );

    // Controller / memory side.
    modport slave (
        output start,
        output q,
        input  complete,
        input  address,
        input  data,
        input  wren
    );

endinterface

// File: rtl/ksa_key_sel.sv
// ksa_key_sel: key index k = i mod KEY_LEN kept as a wrapping counter, plus the
// big-endian byte select (byte 0 is the most significant byte of secret_key).
module ksa_key_sel #(
    parameter int KEY_LEN = ksa_pkg::KEY_LEN,
    parameter int KEY_W   = ksa_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [KEY_W-1:0] secret_key,
    output logic [7:0]       key_byte
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);

    logic [KW-1:0] k_q, k_d;

    // Next key index: clear wins, otherwise wrap from KEY_LEN-1 back to 0.
    always_comb begin
        k_d = k_q;
        if (clear) begin
            k_d = '0;
        end else if (advance) begin
            k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
    end

    // Key index register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Byte mux: unrolled compare against each key byte position.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_LEN; b++) begin
            if (k_q == KW'(b)) begin
                key_byte = secret_key[KEY_W-1-8*b -: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_shuffle.sv
// ksa_shuffle: RC4 KSA swap loop over the shared 256x8 S memory.
// Each iteration reads S[i], updates j, reads S[j], then writes the swapped
// pair back (6 cycles). Completion is a level on bus.complete held in DONE
// until start drops. state_dbg exposes the FSM state.
// Optional build macro KSA_SELF_SWAP_SKIP_EN: when the new j equals i the
// iteration ends right after WT_I (2 cycles, no writes); final S is unchanged.
module ksa_shuffle #(
    parameter int KEY_LEN = ksa_pkg::KEY_LEN,
    parameter int KEY_W   = ksa_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] secret_key,
    ksa_shuffle_if.master    bus,
    output ksa_pkg::state_t  state_dbg
);

    import ksa_pkg::*;

    localparam logic [7:0] I_LAST = 8'(S_DEPTH - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic       k_clear;
    logic       k_advance;
    logic [7:0] key_byte;
    logic [7:0] j_sum;

    ksa_key_sel #(
        .KEY_LEN (KEY_LEN),
        .KEY_W   (KEY_W)
    ) u_key_sel (
        .clk        (clk),
        .reset      (reset),
        .clear      (k_clear),
        .advance    (k_advance),
        .secret_key (secret_key),
        .key_byte   (key_byte)
    );

    // Candidate j for this iteration: j + S[i] + key[k], wrapping at 256.
    always_comb begin
        j_sum = j_q + bus.q + key_byte;
    end

    // Next-state, register updates and memory port decode.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        si_d         = si_q;
        sj_d         = sj_q;
        k_clear      = 1'b0;
        k_advance    = 1'b0;
        bus.address  = 8'h00;
        bus.data     = 8'h00;
        bus.wren     = 1'b0;
        bus.complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    k_clear = 1'b1;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                bus.address = i_q;
                state_d     = WT_I;
            end
            WT_I: begin
                bus.address = i_q;
                si_d        = bus.q;
                j_d         = j_sum;
`ifdef KSA_SELF_SWAP_SKIP_EN
                // Self-swap is a no-op on memory, so end the iteration here.
                if (j_sum == i_q) begin
                    if (i_q == I_LAST) begin
                        state_d = DONE;
                    end else begin
                        i_d       = i_q + 8'd1;
                        k_advance = 1'b1;
                        state_d   = RD_I;
                    end
                end else begin
                    state_d = RD_J;
                end
`else
                state_d = RD_J;
`endif
            end
            RD_J: begin
                bus.address = j_q;
                state_d     = WT_J;
            end
            WT_J: begin
                bus.address = j_q;
                sj_d        = bus.q;
                state_d     = WR_I;
            end
            WR_I: begin
                bus.address = i_q;
                bus.data    = sj_q;
                bus.wren    = 1'b1;
                state_d     = WR_J;
            end
            WR_J: begin
                bus.address = j_q;
                bus.data    = si_q;
                bus.wren    = 1'b1;
                if (i_q == I_LAST) begin
                    state_d = DONE;
                end else begin
                    i_d       = i_q + 8'd1;
                    k_advance = 1'b1;
                    state_d   = RD_I;
                end
            end
            DONE: begin
                bus.complete = 1'b1;
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to zero/IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    // Debug view of the FSM state.
    always_comb begin
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_ksa_shuffle.sv
// tb_ksa_shuffle: self-checking bench for ksa_shuffle with a behavioural
// S memory and a software RC4 KSA reference model.
module tb_ksa_shuffle;

    import ksa_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] secret_key;
    state_t      state_dbg;

    ksa_shuffle_if bus ();

    ksa_shuffle #(
        .KEY_LEN (3),
        .KEY_W   (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .secret_key (secret_key),
        .bus        (bus),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // S memory: 1-cycle registered read, synchronous write, bulk preload
    logic [7:0] mem   [256];
    logic [7:0] pre_s [256];
    logic       do_load = 1'b0;

    always @(posedge clk) begin
        if (do_load) begin
            mem <= pre_s;
        end else if (bus.wren) begin
            mem[bus.address] <= bus.data;
        end
        bus.q <= mem[bus.address];
    end

    // Scoreboard state
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [7:0]  exp_s [256];
    int          exp_lat;
    int          lat_obs;
    bit          timed_out;
    logic [7:0]  addr_tr[$];
    state_t      st_tr[$];

    // Reference model: plain RC4 KSA over a copy of the current memory.
    task automatic model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] j;
        logic [7:0] kb;
        logic [7:0] t;
        s = mem;
        exp_q.delete();
        j = 8'h00;
        exp_lat = 1;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(key >> (8 * (KEY_LEN - 1 - (i % KEY_LEN))));
            j = 8'(int'(j) + int'(s[i]) + int'(kb));
`ifdef KSA_SELF_SWAP_SKIP_EN
            if (j == 8'(i)) begin
                exp_lat += 2;
                continue;
            end
`endif
            exp_q.push_back({8'(i), s[j]});
            exp_q.push_back({j, s[i]});
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            exp_lat += 6;
        end
        exp_s = s;
    endtask

    // Driver: preload memory (identity or random bytes); called at a negedge.
    task automatic load(input bit identity);
        for (int x = 0; x < 256; x++) begin
            pre_s[x] = identity ? 8'(x) : 8'($urandom_range(0, 255));
        end
        do_load = 1'b1;
        @(negedge clk);
        do_load = 1'b0;
    endtask

    // Driver: raise start, record per-cycle trace until complete or timeout.
    // trace[c-1] holds cycle c (cycle 0 = start sampled in IDLE).
    task automatic run_dut(input logic [23:0] key);
        int cyc;
        secret_key = key;
        model(key);
        obs_q.delete();
        addr_tr.delete();
        st_tr.delete();
        lat_obs = -1;
        timed_out = 1'b0;
        cyc = 0;
        bus.start = 1'b1;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            addr_tr.push_back(bus.address);
            st_tr.push_back(state_dbg);
            if (bus.wren) obs_q.push_back({bus.address, bus.data});
            if (bus.complete) begin
                lat_obs = cyc;
                break;
            end
            if (cyc >= 4000) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    // Driver: drop start and let the DUT return to IDLE.
    task automatic finish_run();
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        secret_key = 24'h0;
        repeat (2) @(negedge clk);
        checks++; if (bus.address !== 8'h00) begin failures++; $display("FAIL reset_address got=%0h exp=0", bus.address); end
        checks++; if (bus.data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.data); end
        checks++; if (bus.wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%0b exp=0", bus.wren); end
        checks++; if (bus.complete !== 1'b0) begin failures++; $display("FAIL reset_complete got=%0b exp=0", bus.complete); end
        checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_iter0_key010203();
        load(1'b1);
        run_dut(24'h010203);
        checks++; if (timed_out) begin failures++; $display("FAIL iter0_timeout got=timeout exp=complete"); end
        checks++; if (st_tr[0] !== RD_I) begin failures++; $display("FAIL iter0_state_c1 got=%0d exp=%0d", st_tr[0], RD_I); end
        checks++; if (addr_tr[0] !== 8'h00) begin failures++; $display("FAIL iter0_read_i got=%0h exp=0", addr_tr[0]); end
        checks++; if (addr_tr[2] !== 8'h01) begin failures++; $display("FAIL iter0_read_j got=%0h exp=1", addr_tr[2]); end
        checks++; if (obs_q.size() < 2 || obs_q[0] !== 16'h0001) begin failures++; $display("FAIL iter0_write0 got=%0h exp=0001", (obs_q.size() > 0) ? obs_q[0] : 16'hffff); end
        checks++; if (obs_q.size() < 2 || obs_q[1] !== 16'h0100) begin failures++; $display("FAIL iter0_write1 got=%0h exp=0100", (obs_q.size() > 1) ? obs_q[1] : 16'hffff); end
        checks++; if (lat_obs != exp_lat) begin failures++; $display("FAIL iter0_latency got=%0d exp=%0d", lat_obs, exp_lat); end
        finish_run();
    endtask

    // Zero key on identity S; leaves the DUT in DONE with start still high.
    task automatic test_zero_key();
        int idx;
        int bad;
        load(1'b1);
        run_dut(24'h000000);
        checks++; if (timed_out) begin failures++; $display("FAIL zero_timeout got=timeout exp=complete"); end
        checks++; if (lat_obs != exp_lat) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat_obs, exp_lat); end
`ifdef KSA_SELF_SWAP_SKIP_EN
        checks++; if (st_tr[2] !== RD_I || addr_tr[2] !== 8'h01) begin failures++; $display("FAIL skip_iter1_start got=%0d/%0h exp=%0d/01", st_tr[2], addr_tr[2], RD_I); end
        checks++; if (st_tr[4] !== RD_I || addr_tr[4] !== 8'h02) begin failures++; $display("FAIL skip_iter2_start got=%0d/%0h exp=%0d/02", st_tr[4], addr_tr[4], RD_I); end
        checks++; if (obs_q.size() < 1 || obs_q[0] !== 16'h0203) begin failures++; $display("FAIL skip_no_self_write got=%0h exp=0203", (obs_q.size() > 0) ? obs_q[0] : 16'hffff); end
`else
        checks++; if (lat_obs != 1537) begin failures++; $display("FAIL zero_latency_1537 got=%0d exp=1537", lat_obs); end
        checks++; if (st_tr[6] !== RD_I || addr_tr[6] !== 8'h01) begin failures++; $display("FAIL iter1_start got=%0d/%0h exp=%0d/01", st_tr[6], addr_tr[6], RD_I); end
        checks++; if (obs_q.size() != 512) begin failures++; $display("FAIL zero_write_count got=%0d exp=512", obs_q.size()); end
`endif
        idx = -1;
        for (int n = 0; n < obs_q.size(); n++) begin
            if (obs_q[n][15:8] != obs_q[n][7:0]) begin
                idx = n;
                break;
            end
        end
        checks++; if (idx < 0 || obs_q[idx] !== 16'h0203) begin failures++; $display("FAIL zero_first_swap_a got=%0h exp=0203", (idx >= 0) ? obs_q[idx] : 16'hffff); end
        checks++; if (idx < 0 || idx + 1 >= obs_q.size() || obs_q[idx+1] !== 16'h0302) begin failures++; $display("FAIL zero_first_swap_b idx=%0d exp=0302", idx); end
        bad = 0;
        for (int x = 0; x < 256; x++) if (mem[x] !== exp_s[x]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL zero_final_s got=%0d_bad_bytes exp=0", bad); end
    endtask

    task automatic test_hold_done();
        int bad_c;
        int bad_w;
        int bad;
        bad_c = 0;
        bad_w = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.complete !== 1'b1) bad_c++;
            if (bus.wren !== 1'b0) bad_w++;
        end
        checks++; if (bad_c != 0) begin failures++; $display("FAIL hold_complete got=%0d_low_cycles exp=0", bad_c); end
        checks++; if (bad_w != 0) begin failures++; $display("FAIL hold_no_wren got=%0d_write_cycles exp=0", bad_w); end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.complete !== 1'b0) begin failures++; $display("FAIL hold_release_complete got=%0b exp=0", bus.complete); end
        checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL hold_release_state got=%0d exp=%0d", state_dbg, IDLE); end
        @(negedge clk);
        load(1'b0);
        run_dut(24'($urandom));
        checks++; if (st_tr[0] !== RD_I) begin failures++; $display("FAIL rerun_start got=%0d exp=%0d", st_tr[0], RD_I); end
        checks++; if (lat_obs != exp_lat) begin failures++; $display("FAIL rerun_latency got=%0d exp=%0d", lat_obs, exp_lat); end
        bad = 0;
        for (int x = 0; x < 256; x++) if (mem[x] !== exp_s[x]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rerun_final_s got=%0d_bad_bytes exp=0", bad); end
        finish_run();
    endtask

    task automatic test_reset_mid_run();
        logic [23:0] key;
        int bad;
        key = 24'($urandom);
        load(1'b0);
        secret_key = key;
        bus.start = 1'b1;
        repeat (700) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.address !== 8'h00 || bus.data !== 8'h00 || bus.wren !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%0h/%0h/%0b exp=0/0/0", bus.address, bus.data, bus.wren); end
        checks++; if (bus.complete !== 1'b0) begin failures++; $display("FAIL midreset_complete got=%0b exp=0", bus.complete); end
        checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL midreset_state got=%0d exp=%0d", state_dbg, IDLE); end
        @(negedge clk);
        reset = 1'b0;
        run_dut(key);
        checks++; if (st_tr[0] !== RD_I || addr_tr[0] !== 8'h00) begin failures++; $display("FAIL midreset_restart got=%0d/%0h exp=%0d/00", st_tr[0], addr_tr[0], RD_I); end
        checks++; if (lat_obs != exp_lat) begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", lat_obs, exp_lat); end
        bad = 0;
        for (int x = 0; x < 256; x++) if (mem[x] !== exp_s[x]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL midreset_final_s got=%0d_bad_bytes exp=0", bad); end
        finish_run();
    endtask

    task automatic test_random();
        int bad;
        for (int r = 0; r < 3; r++) begin
            load(1'b0);
            run_dut(24'($urandom));
            checks++; if (lat_obs != exp_lat) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", r, lat_obs, exp_lat); end
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_write_count got=%0d exp=%0d", r, obs_q.size(), exp_q.size()); end
            for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
                checks++;
                if (obs_q[n] !== exp_q[n]) begin
                    failures++;
                    $display("FAIL rand%0d_write%0d got=%0h exp=%0h", r, n, obs_q[n], exp_q[n]);
                end
            end
            bad = 0;
            for (int x = 0; x < 256; x++) if (mem[x] !== exp_s[x]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rand%0d_final_s got=%0d_bad_bytes exp=0", r, bad); end
            finish_run();
        end
    endtask

    initial begin
        test_reset();
        test_iter0_key010203();
        test_zero_key();
        test_hold_done();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
